// File: rtl/dut_vector_seq_pkg.sv
// Shared encodings for the vector-set sequencer: register kinds, FSM states,
// strobe-vector bit positions and the test-cycle length clamp.
package dut_vector_seq_pkg;

    localparam int DATA_W    = 128;
    localparam int NUM_KINDS = 4;
    localparam int CNT_BITS  = 9;

    typedef enum logic [1:0] {
        KIND_SIG      = 2'd0,
        KIND_FF       = 2'd1,
        KIND_TEMPLATE = 2'd2,
        KIND_CYCLE    = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_XFER0 = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    // Strobe vectors are indexed by kind encoding.
    localparam int STB_SIG      = 0;
    localparam int STB_FF       = 1;
    localparam int STB_TEMPLATE = 2;
    localparam int STB_CYCLE    = 3;

    // A programmed length of 0 means 256; anything shorter than min_cycle is raised.
    function automatic logic [CNT_BITS-1:0] clamp_len(input logic [7:0] raw, input int min_cycle);
        logic [CNT_BITS-1:0] len;
        len = (raw == 8'd0) ? CNT_BITS'(256) : {1'b0, raw};
        if (len < CNT_BITS'(min_cycle)) begin
            len = CNT_BITS'(min_cycle);
        end
        return len;
    endfunction

endpackage

// File: rtl/dut_vector_seq_cycle_timer.sv
// Test-cycle timer: latches the clamped cycle length on START and counts
// clocks 0..len-1 while the sequencer is in RUN.
module dut_cycle_timer
    import dut_vector_seq_pkg::*;
#(
    parameter int MIN_CYCLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_load,
    input  logic [7:0] cycle_length,
    input  logic       run,
    output logic       cycle_tick,
    output logic       ready_block
);

    logic [CNT_BITS-1:0] len_reg;
    logic [CNT_BITS-1:0] cnt_reg;
    logic [CNT_BITS-1:0] cnt_next;
    logic                at_last;
    logic                at_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg <= CNT_BITS'(MIN_CYCLE);
        end else if (start_load) begin
            len_reg <= clamp_len(cycle_length, MIN_CYCLE);
        end
    end

    assign at_last  = (cnt_reg == len_reg - CNT_BITS'(1));
    assign at_block = (cnt_reg == len_reg - CNT_BITS'(2));

    // Held at zero outside RUN so the first RUN clock is always cnt 0.
    always_comb begin
        cnt_next = cnt_reg + CNT_BITS'(1);
        if (!run || at_last) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cycle_tick  = run & at_last;
    assign ready_block = run & at_block;

endmodule

// File: rtl/dut_vector_seq.sv
// Vector-set sequencer: streams host words onto bus128 with per-kind load strobes
// and commits each complete set to the wrapper at test-cycle boundaries.
module dut_vector_seq
    import dut_vector_seq_pkg::*;
#(
    parameter int MIN_CYCLE = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        cycle_length,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [DATA_W-1:0] vec_data,
    input  logic [1:0]        vec_kind,
    input  logic              vec_last,
    output logic [DATA_W-1:0] bus128,
    output logic              sig_load,
    output logic              ff_load,
    output logic              template_load,
    output logic              cycle_load,
    output logic              sig_transfer,
    output logic              ff_transfer,
    output logic              template_transfer,
    output logic              cycle_transfer,
    output logic              perform_test,
    output logic              cycle_tick,
    output logic              busy,
    output logic              underrun,
    output logic [CNT_W-1:0]  set_count
);

    state_e               state_reg;
    state_e               state_next;
    logic [DATA_W-1:0]    bus_reg;
    logic [NUM_KINDS-1:0] load_reg;
    logic [NUM_KINDS-1:0] mask_reg;
    logic [NUM_KINDS-1:0] mask_next;
    logic [NUM_KINDS-1:0] kind_onehot;
    logic [NUM_KINDS-1:0] xfer_vec;
    logic                 pending_reg;
    logic                 pending_next;
    logic                 stop_req_reg;
    logic                 underrun_reg;
    logic [CNT_W-1:0]     set_count_reg;
    logic                 accept;
    logic                 boundary;
    logic                 ready_block;
    logic                 xfer_fire;
    logic                 stop_hit;
    logic                 start_run;
    logic                 run_active;

    assign run_active = (state_reg == ST_RUN);
    assign start_run  = (state_reg == ST_IDLE) && start;
    assign stop_hit   = stop | stop_req_reg;
    assign accept     = vec_valid & vec_ready;

    dut_cycle_timer #(
        .MIN_CYCLE(MIN_CYCLE)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load   (start_run),
        .cycle_length (cycle_length),
        .run          (run_active),
        .cycle_tick   (boundary),
        .ready_block  (ready_block)
    );

    for (genvar gi = 0; gi < NUM_KINDS; gi++) begin : g_kind
        assign kind_onehot[gi] = (vec_kind == 2'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_FILL;
            ST_FILL: begin
                if (stop_hit) begin
                    state_next = ST_IDLE;
                end else if (pending_reg) begin
                    state_next = ST_XFER0;
                end
            end
            ST_XFER0: state_next = stop_hit ? ST_IDLE : ST_RUN;
            ST_RUN:   if (boundary && stop_hit) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Ready drops one clock before a boundary so no load strobe can land on a transfer.
    always_comb begin
        vec_ready    = 1'b0;
        perform_test = 1'b0;
        busy         = 1'b0;
        xfer_fire    = 1'b0;
        case (state_reg)
            ST_FILL: begin
                vec_ready = !pending_reg;
                busy      = 1'b1;
            end
            ST_XFER0: begin
                xfer_fire = 1'b1;
                busy      = 1'b1;
            end
            ST_RUN: begin
                vec_ready    = !pending_reg && !ready_block;
                perform_test = 1'b1;
                busy         = 1'b1;
                xfer_fire    = boundary && pending_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        mask_next    = mask_reg;
        pending_next = pending_reg;
        if (xfer_fire) begin
            mask_next    = '0;
            pending_next = 1'b0;
        end
        if (accept) begin
            mask_next = mask_next | kind_onehot;
            if (vec_last) begin
                pending_next = 1'b1;
            end
        end
        // Leaving the run discards any partial set.
        if (state_next == ST_IDLE) begin
            mask_next    = '0;
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_reg       <= '0;
            load_reg      <= '0;
            mask_reg      <= '0;
            pending_reg   <= 1'b0;
            stop_req_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            set_count_reg <= '0;
        end else begin
            load_reg     <= accept ? kind_onehot : '0;
            mask_reg     <= mask_next;
            pending_reg  <= pending_next;
            stop_req_reg <= (state_next != ST_IDLE) &&
                            (stop_req_reg || (stop && (state_reg != ST_IDLE)));
            if (accept) begin
                bus_reg <= vec_data;
            end
            if (start_run) begin
                underrun_reg <= 1'b0;
            end else if (boundary && !pending_reg) begin
                underrun_reg <= 1'b1;
            end
            if (start_run) begin
                set_count_reg <= '0;
            end else if (xfer_fire && (set_count_reg != '1)) begin
                set_count_reg <= set_count_reg + CNT_W'(1);
            end
        end
    end

    assign xfer_vec = xfer_fire ? mask_reg : '0;

    assign bus128            = bus_reg;
    assign sig_load          = load_reg[STB_SIG];
    assign ff_load           = load_reg[STB_FF];
    assign template_load     = load_reg[STB_TEMPLATE];
    assign cycle_load        = load_reg[STB_CYCLE];
    assign sig_transfer      = xfer_vec[STB_SIG];
    assign ff_transfer       = xfer_vec[STB_FF];
    assign template_transfer = xfer_vec[STB_TEMPLATE];
    assign cycle_transfer    = xfer_vec[STB_CYCLE];
    assign cycle_tick        = boundary;
    assign underrun          = underrun_reg;
    assign set_count         = set_count_reg;

endmodule

// File: tb/tb_dut_vector_seq.sv
// Self-checking bench for dut_vector_seq: directed scenarios plus random traffic,
// every clock compared against a transaction-level model of the sequencer.
module tb_dut_vector_seq;

    localparam int MIN_CYCLE = 4;
    localparam int CNT_W     = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [7:0]         cycle_length = 8'd0;
    logic               vec_valid = 1'b0;
    logic               vec_ready;
    logic [127:0]       vec_data = '0;
    logic [1:0]         vec_kind = 2'd0;
    logic               vec_last = 1'b0;
    logic [127:0]       bus128;
    logic               sig_load, ff_load, template_load, cycle_load;
    logic               sig_transfer, ff_transfer, template_transfer, cycle_transfer;
    logic               perform_test, cycle_tick, busy, underrun;
    logic [CNT_W-1:0]   set_count;

    dut_vector_seq #(.MIN_CYCLE(MIN_CYCLE), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cycle_length(cycle_length),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_kind(vec_kind),
        .vec_last(vec_last), .bus128(bus128), .sig_load(sig_load), .ff_load(ff_load),
        .template_load(template_load), .cycle_load(cycle_load), .sig_transfer(sig_transfer),
        .ff_transfer(ff_transfer), .template_transfer(template_transfer),
        .cycle_transfer(cycle_transfer), .perform_test(perform_test), .cycle_tick(cycle_tick),
        .busy(busy), .underrun(underrun), .set_count(set_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Host word queue.
    typedef struct {
        logic [127:0] d;
        logic [1:0]   k;
        logic         l;
    } word_t;
    word_t hq[$];

    task automatic push(input logic [127:0] d, input logic [1:0] k, input logic l);
        word_t w;
        w.d = d; w.k = k; w.l = l;
        hq.push_back(w);
    endtask

    // Reference model: run position is derived from absolute clock index arithmetic,
    // the set under construction is just a set of kinds plus a "complete" flag.
    typedef enum int {P_IDLE, P_FILL, P_XFER, P_RUN} mphase_t;
    mphase_t      m_phase;
    int           cyc = 0;
    int           m_t_run;
    int           m_len;
    logic [3:0]   m_have;
    bit           m_done;
    bit           m_stop;
    bit           m_under;
    int           m_count;
    logic [127:0] m_bus;
    logic [3:0]   m_load;
    int           last_tick = -1;

    function automatic int spec_len(input logic [7:0] cl);
        int n;
        n = (cl == 8'd0) ? 256 : int'(cl);
        if (n < MIN_CYCLE) n = MIN_CYCLE;
        return n;
    endfunction

    function automatic int cur_pos();
        return (cyc - m_t_run) % m_len;
    endfunction

    function automatic bit exp_ready();
        if (m_done) return 1'b0;
        if (m_phase == P_FILL) return 1'b1;
        if (m_phase == P_RUN && cur_pos() != m_len - 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_len = MIN_CYCLE; m_t_run = 0;
        m_have = '0; m_done = 0; m_stop = 0; m_under = 0;
        m_count = 0; m_bus = '0; m_load = '0;
    endtask

    task automatic go_idle();
        m_phase = P_IDLE; m_have = '0; m_done = 0; m_stop = 0;
    endtask

    task automatic bump();
        if (m_count < (1 << CNT_W) - 1) m_count++;
    endtask

    task automatic model_step(output bit acc);
        mphase_t old;
        bit stp;
        bit bnd;
        old = m_phase;
        acc = vec_valid && exp_ready();
        bnd = (m_phase == P_RUN) && (cur_pos() == m_len - 1);
        m_load = '0;
        if (acc) begin
            m_load[vec_kind] = 1'b1;
            m_bus = vec_data;
        end
        stp = stop || m_stop;
        case (m_phase)
            P_IDLE: if (start) begin
                m_len = spec_len(cycle_length);
                m_under = 0; m_count = 0; m_have = '0; m_done = 0;
                m_phase = P_FILL;
            end
            P_FILL: begin
                if (stp) go_idle();
                else begin
                    if (m_done) m_phase = P_XFER;
                    if (acc) begin m_have[vec_kind] = 1'b1; if (vec_last) m_done = 1; end
                end
            end
            P_XFER: begin
                bump(); m_have = '0; m_done = 0;
                if (stp) go_idle();
                else begin m_phase = P_RUN; m_t_run = cyc + 1; end
            end
            P_RUN: begin
                if (bnd) begin
                    if (m_done) begin bump(); m_have = '0; m_done = 0; end
                    else m_under = 1;
                    if (stp) go_idle();
                end
                if (m_phase == P_RUN && acc) begin
                    m_have[vec_kind] = 1'b1;
                    if (vec_last) m_done = 1;
                end
            end
            default: ;
        endcase
        if (old != P_IDLE && m_phase != P_IDLE && stop) m_stop = 1;
        cyc++;
    endtask

    task automatic compare_all();
        bit run, bnd, xf;
        logic [3:0] exp_xfer;
        run = (m_phase == P_RUN);
        bnd = run && (cur_pos() == m_len - 1);
        xf  = (m_phase == P_XFER) || (bnd && m_done);
        exp_xfer = xf ? m_have : 4'b0;
        check_val("strobes",
                  {cycle_transfer, template_transfer, ff_transfer, sig_transfer,
                   cycle_load, template_load, ff_load, sig_load},
                  {exp_xfer, m_load});
        check_val("status", {vec_ready, perform_test, cycle_tick, busy, underrun},
                  {exp_ready(), run, bnd, m_phase != P_IDLE, m_under});
        check_val("bus128", bus128, m_bus);
        check_val("set_count", 128'(set_count), 128'(m_count));
        if (!run) last_tick = -1;
        else if (cycle_tick) begin
            if (last_tick >= 0) check_val("tick_period", 128'(cyc - last_tick), 128'(m_len));
            last_tick = cyc;
        end
    endtask

    // One clock: drive inputs, compare current outputs, advance the model, step the clock.
    task automatic tick(input bit st, input bit sp, input bit offer);
        bit acc;
        start = st;
        stop  = sp;
        if (offer && hq.size() > 0) begin
            vec_valid = 1'b1; vec_data = hq[0].d; vec_kind = hq[0].k; vec_last = hq[0].l;
        end else begin
            vec_valid = 1'b0; vec_data = {$urandom, $urandom, $urandom, $urandom};
            vec_kind = 2'($urandom_range(0, 3)); vec_last = 1'($urandom_range(0, 1));
        end
        compare_all();
        model_step(acc);
        if (acc) begin
            $display("word kind=%0d last=%0d data=%032h t=%0t", vec_kind, vec_last, vec_data, $time);
            hq.delete(0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && m_phase != P_IDLE; i++) tick(0, 0, 1);
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < 600 && !(m_phase == P_RUN && cur_pos() == p); i++) tick(0, 0, 1);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("reset_bus", bus128, '0);
        check_val("reset_outputs",
                  128'({vec_ready, sig_load, ff_load, template_load, cycle_load, sig_transfer,
                        ff_transfer, template_transfer, cycle_transfer, perform_test,
                        cycle_tick, busy, underrun, set_count}), '0);
        model_reset();
        hq.delete();
        start = 0; stop = 0; vec_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick(0, 0, 0);

        // Full four-kind set, then a SIG-only set, then underrun, then stop.
        cycle_length = 8'd8;
        push({16{8'hA5}}, 2'd0, 1'b0);
        push({16{8'h0F}}, 2'd1, 1'b0);
        push({16{8'h00}}, 2'd2, 1'b0);
        push({16{8'hFF}}, 2'd3, 1'b1);
        tick(1, 0, 1);
        repeat (12) tick(0, 0, 1);
        push({$urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b1);
        repeat (20) tick(0, 0, 1);
        repeat (20) tick(0, 0, 1);
        tick(1, 0, 1);
        tick(0, 1, 1);
        wait_idle();

        // START clears underrun; reset mid-run at cnt 3.
        push({$urandom, $urandom, $urandom, $urandom}, 2'd1, 1'b1);
        tick(1, 0, 1);
        run_to_pos(3);
        async_reset();
        repeat (2) tick(0, 0, 1);

        // Clamp to MIN_CYCLE and length 0 meaning 256.
        cycle_length = 8'd2;
        push({$urandom, $urandom, $urandom, $urandom}, 2'd2, 1'b1);
        tick(1, 0, 1);
        repeat (30) tick(0, 0, 1);
        tick(0, 1, 1);
        wait_idle();
        cycle_length = 8'd0;
        push({$urandom, $urandom, $urandom, $urandom}, 2'd3, 1'b1);
        tick(1, 0, 1);
        repeat (560) tick(0, 0, 1);
        tick(0, 1, 1);
        wait_idle();

        // STOP at cnt 2 with a set pending, then STOP during FILL.
        cycle_length = 8'd8;
        push({$urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b1);
        tick(1, 0, 1);
        run_to_pos(0);
        push({$urandom, $urandom, $urandom, $urandom}, 2'd1, 1'b1);
        run_to_pos(2);
        tick(0, 1, 1);
        wait_idle();
        repeat (2) tick(0, 0, 1);
        push({$urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b0);
        push({$urandom, $urandom, $urandom, $urandom}, 2'd1, 1'b0);
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(0, 1, 1);
        repeat (3) tick(0, 0, 0);
        hq.delete();

        // Random traffic.
        for (int r = 0; r < 25; r++) begin
            int n;
            cycle_length = (r % 5 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 12));
            for (int w = 0; w < int'($urandom_range(1, 8)); w++)
                push({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 2) == 0));
            tick(1, 0, 1);
            n = $urandom_range(40, 150);
            for (int i = 0; i < n; i++) begin
                if (hq.size() < 6 && $urandom_range(0, 3) == 0)
                    push({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)),
                         ($urandom_range(0, 2) == 0));
                cycle_length = 8'($urandom_range(1, 12));
                tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 3) != 0));
            end
            tick(0, 1, 1);
            wait_idle();
            tick(0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
